// File: rtl/keccak_squeeze_serializer.sv
// keccak_squeeze_serializer
//
// Purpose:
//   Streams the rate block of a Keccak sponge core as WORD_W-bit words over a
//   valid/ready interface. A request asks for an arbitrary number of words.
//   When one block runs out before the request is satisfied, the block pulses
//   the core's squeeze input and waits for a fresh block. NewHope sampling
//   uses it to pull a long SHAKE/SHA3 output stream.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   start        request strobe, sampled only while idle
//   req_words    number of words to emit, sampled with start
//   busy         high whenever a request is in progress
//   blk_in       rate block from the sponge core (word 0 in the MSBs)
//   blk_valid    block-ready flag from the sponge core
//   squeeze      one-cycle pulse asking the core for the next block
//   dout         current output word
//   dout_valid   dout holds a valid word
//   dout_ready   consumer accepts the word
//   dout_last    marks the final word of the request
//   done         one-cycle pulse after the final word is accepted
module keccak_squeeze_serializer #(
    parameter int RATE_BITS = 1088,
    parameter int WORD_W    = 32,
    parameter int LEN_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     req_words,
    output logic                 busy,
    input  logic [RATE_BITS-1:0] blk_in,
    input  logic                 blk_valid,
    output logic                 squeeze,
    output logic [WORD_W-1:0]    dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 dout_last,
    output logic                 done
);

    localparam int WPB   = RATE_BITS / WORD_W;
    localparam int IDX_W = $clog2(WPB + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPB - 1);
    localparam logic [LEN_W-1:0] ONE_LEFT = LEN_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BLK,
        ST_EMIT,
        ST_SQZ,
        ST_WAIT_LOW,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     remaining_q, remaining_d;
    logic [IDX_W-1:0]     word_idx_q, word_idx_d;
    logic [RATE_BITS-1:0] shadow_q, shadow_d;
    logic                 busy_q, busy_d;
    logic                 squeeze_q, squeeze_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 dout_last_q, dout_last_d;
    logic                 done_q, done_d;
    logic                 zero_req;
    logic                 accept;

    // dout_valid_q is high exactly in EMIT, so dout_ready is ignored elsewhere.
    assign accept = dout_valid_q & dout_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        word_idx_d  = word_idx_q;
        shadow_d    = shadow_q;
        zero_req    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (req_words == '0) begin
                        zero_req = 1'b1;
                    end else begin
                        remaining_d = req_words;
                        state_d     = ST_WAIT_BLK;
                    end
                end
            end
            ST_WAIT_BLK: begin
                if (blk_valid) begin
                    shadow_d   = blk_in;
                    word_idx_d = '0;
                    state_d    = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (accept) begin
                    // remaining is at least 1 here, so the decrement cannot wrap.
                    remaining_d = remaining_q - ONE_LEFT;
                    word_idx_d  = word_idx_q + IDX_W'(1);
                    shadow_d    = {shadow_q[RATE_BITS-WORD_W-1:0], {WORD_W{1'b0}}};
                    if (remaining_q == ONE_LEFT) begin
                        state_d = ST_DONE;
                    end else if (word_idx_q == LAST_IDX) begin
                        state_d = ST_SQZ;
                    end
                end
            end
            ST_SQZ: begin
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                // The core still shows the old block until it drops its flag.
                if (!blk_valid) begin
                    state_d = ST_WAIT_BLK;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        busy_d       = (state_d != ST_IDLE);
        squeeze_d    = (state_d == ST_SQZ);
        dout_valid_d = (state_d == ST_EMIT);
        dout_last_d  = (state_d == ST_EMIT) && (remaining_d == ONE_LEFT);
        done_d       = (state_d == ST_DONE) || zero_req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            word_idx_q   <= '0;
            shadow_q     <= '0;
            busy_q       <= 1'b0;
            squeeze_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            word_idx_q   <= word_idx_d;
            shadow_q     <= shadow_d;
            busy_q       <= busy_d;
            squeeze_q    <= squeeze_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign squeeze    = squeeze_q;
    assign dout       = shadow_q[RATE_BITS-1 -: WORD_W];
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign done       = done_q;

endmodule

// File: tb/tb_keccak_squeeze_serializer.sv
// tb_keccak_squeeze_serializer
//
// Purpose:
//   Self-checking bench for keccak_squeeze_serializer. A small sponge-core
//   model presents numbered blocks (block b, word k = b*0x100 + k), drops its
//   ready flag one cycle after a squeeze and re-raises it 23 cycles later with
//   the next block. A request model predicts the word stream from the request
//   length and the block the request started on; a compare process checks
//   every output cycle against it, and directed literals pin the model.
//
// Ports: none (top-level bench).
module tb_keccak_squeeze_serializer;

    localparam int RATE_BITS = 1088;
    localparam int WORD_W    = 32;
    localparam int LEN_W     = 16;
    localparam int WPB       = 34;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [LEN_W-1:0]     req_words;
    logic                 busy;
    logic [RATE_BITS-1:0] blk_in;
    logic                 blk_valid;
    logic                 squeeze;
    logic [WORD_W-1:0]    dout;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 dout_last;
    logic                 done;

    keccak_squeeze_serializer #(
        .RATE_BITS(RATE_BITS),
        .WORD_W   (WORD_W),
        .LEN_W    (LEN_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .req_words (req_words),
        .busy      (busy),
        .blk_in    (blk_in),
        .blk_valid (blk_valid),
        .squeeze   (squeeze),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_last (dout_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Request model state.
    bit  exp_active = 1'b0;
    int  exp_n      = 0;
    int  exp_pos    = 0;
    int  exp_blk    = 0;
    int  start_cyc  = 0;

    // Observations.
    int  acc_count       = 0;
    int  done_count      = 0;
    int  sqz_count       = 0;
    int  valid_seen      = 0;
    int  last_acc_cyc    = -10;
    int  done_cyc        = -10;
    int  first_valid_cyc = -1;
    logic [WORD_W-1:0] got_words[$];
    int  acc_cyc[$];

    // Sponge core model.
    int  blk_idx    = 0;
    int  countdown  = 0;
    bit  drop_next  = 1'b0;

    function automatic logic [RATE_BITS-1:0] make_block(input int idx);
        logic [RATE_BITS-1:0] b;
        b = '0;
        for (int k = 0; k < WPB; k++) begin
            b[RATE_BITS-1-WORD_W*k -: WORD_W] = WORD_W'(idx * 256 + k);
        end
        return b;
    endfunction

    // Word j of a request that started on block blk0.
    function automatic logic [WORD_W-1:0] model_word(input int blk0, input int j);
        return WORD_W'((blk0 + j / WPB) * 256 + j % WPB);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    initial begin
        blk_in    = make_block(0);
        blk_valid = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (drop_next) begin
                blk_valid = 1'b0;
                countdown = 23;
                drop_next = 1'b0;
            end else if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    blk_idx++;
                    blk_in    = make_block(blk_idx);
                    blk_valid = 1'b1;
                end
            end
            if (squeeze) drop_next = 1'b1;
        end
    end

    // Per-cycle comparison against the request model.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (dout_valid) begin
                bit want;
                want = exp_active && (exp_pos < exp_n);
                valid_seen++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                checkOutput("valid_in_request", 64'(dout_valid), 64'(want));
                if (want) begin
                    checkOutput("dout_word", 64'(dout), 64'(model_word(exp_blk, exp_pos)));
                    checkOutput("dout_last", 64'(dout_last), 64'(exp_pos == exp_n - 1));
                    if (dout_ready) begin
                        got_words.push_back(dout);
                        acc_cyc.push_back(cyc);
                        last_acc_cyc = cyc;
                        exp_pos++;
                        acc_count++;
                    end
                end
            end else begin
                checkOutput("last_without_valid", 64'(dout_last), 64'(0));
            end
            if (squeeze) begin
                sqz_count++;
                checkOutput("squeeze_legal",
                    64'(exp_active && exp_pos > 0 && exp_pos % WPB == 0 &&
                        exp_pos < exp_n && cyc == last_acc_cyc + 1), 64'(1));
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
                checkOutput("done_expected", 64'(exp_active), 64'(1));
                checkOutput("done_after_all_words", 64'(exp_pos), 64'(exp_n));
                exp_active = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input int n);
        @(posedge clk);
        #1;
        exp_n           = n;
        exp_pos         = 0;
        exp_blk         = blk_idx;
        exp_active      = 1'b1;
        first_valid_cyc = -1;
        got_words.delete();
        acc_cyc.delete();
        start     = 1'b1;
        req_words = LEN_W'(n);
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_count;
        for (int i = 0; i < budget && done_count == d0; i++) @(posedge clk);
        checkOutput("done_pulse_count", 64'(done_count - d0), 64'(1));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s0, v0, d0, base;
        int pat[7] = '{1, 0, 0, 1, 0, 1, 1};

        reset      = 1'b1;
        start      = 1'b0;
        req_words  = '0;
        dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", 64'({busy, squeeze, dout_valid, dout_last, done, dout}), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Short request inside one block.
        dout_ready = 1'b1;
        applyStimulus(8);
        wait_done(100);
        checkOutput("t1_count", 64'(got_words.size()), 64'(8));
        checkOutput("t1_word0", 64'(got_words[0]), 64'h0);
        checkOutput("t1_word7", 64'(got_words[7]), 64'h7);
        checkOutput("t1_back_to_back", 64'(acc_cyc[7] - acc_cyc[0]), 64'(7));
        checkOutput("t1_first_valid_latency", 64'(first_valid_cyc - start_cyc), 64'(2));
        checkOutput("t1_done_latency", 64'(done_cyc - last_acc_cyc), 64'(1));
        checkOutput("t1_no_squeeze", 64'(sqz_count), 64'(0));

        // Exactly one full block: no squeeze.
        applyStimulus(34);
        wait_done(100);
        checkOutput("t2_count", 64'(got_words.size()), 64'(34));
        checkOutput("t2_word33", 64'(got_words[33]), 64'h21);
        checkOutput("t2_no_squeeze", 64'(sqz_count), 64'(0));

        // One word past the block: one squeeze and a fresh block.
        applyStimulus(35);
        wait_done(200);
        checkOutput("t3_count", 64'(got_words.size()), 64'(35));
        checkOutput("t3_word33", 64'(got_words[33]), 64'h21);
        checkOutput("t3_word34", 64'(got_words[34]), 64'h100);
        checkOutput("t3_one_squeeze", 64'(sqz_count), 64'(1));
        checkOutput("t3_done_latency", 64'(done_cyc - last_acc_cyc), 64'(1));

        // Core is reset between independent hashes.
        blk_idx   = 0;
        blk_in    = make_block(0);
        blk_valid = 1'b1;

        // Backpressure.
        dout_ready = 1'b0;
        applyStimulus(4);
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            dout_ready = pat[i][0];
            @(posedge clk);
            #1;
        end
        wait_done(50);
        checkOutput("t4_count", 64'(got_words.size()), 64'(4));
        for (int i = 0; i < 4 && i < got_words.size(); i++) begin
            checkOutput("t4_word", 64'(got_words[i]), 64'(i));
        end
        checkOutput("t4_accept_span", 64'(acc_cyc[3] - acc_cyc[0]), 64'(6));

        // Zero-length request.
        v0 = valid_seen;
        s0 = sqz_count;
        applyStimulus(0);
        wait_done(10);
        checkOutput("t5_done_latency", 64'(done_cyc - start_cyc), 64'(1));
        checkOutput("t5_no_valid", 64'(valid_seen - v0), 64'(0));
        checkOutput("t5_no_squeeze", 64'(sqz_count - s0), 64'(0));
        checkOutput("t5_idle", 64'(busy), 64'(0));

        // Reset in the middle of a request.
        base = acc_count;
        d0   = done_count;
        s0   = sqz_count;
        applyStimulus(20);
        for (int i = 0; i < 100 && acc_count < base + 10; i++) @(negedge clk);
        checkOutput("t6_ten_words", 64'(acc_count - base >= 10), 64'(1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_active = 1'b0;
        reset      = 1'b0;
        @(negedge clk);
        checkOutput("t6_reset_outputs", 64'({busy, squeeze, dout_valid, dout_last, done, dout}), 64'(0));
        repeat (30) @(posedge clk);
        #1;
        checkOutput("t6_no_done", 64'(done_count - d0), 64'(0));
        checkOutput("t6_no_squeeze", 64'(sqz_count - s0), 64'(0));

        // start held high while busy must not change the request.
        dout_ready = 1'b0;
        applyStimulus(5);
        start     = 1'b1;
        req_words = LEN_W'(9);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        checkOutput("t6_busy_while_held", 64'(busy), 64'(1));
        start      = 1'b0;
        dout_ready = 1'b1;
        wait_done(50);
        checkOutput("t6b_count", 64'(got_words.size()), 64'(5));
        checkOutput("t6b_word4", 64'(got_words[4]), 64'h4);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
